id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, stall refresh, flush and bubble counting
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [WIDTH-1:0] id_rs_val,
  input  logic [WIDTH-1:0] id_rt_val,
  input  logic [15:0]      id_imm,
  input  logic             id_imm_sext,
  input  logic [4:0]       id_shamt,
  input  logic             id_use_shamt,
  input  logic             id_use_imm,
  input  logic [3:0]       id_alu_sel,
  input  logic             id_reg_write,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  input  logic             ex_stall,
  input  logic             ex_flush,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       ALU_Sel,
  output logic             ex_valid,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_reg_write,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic [WIDTH-1:0] rs_fwd, rt_fwd, imm_ext, shamt_ext, a_next, b_next, a_hold, b_hold;
  logic [4:0]       a_src, b_src, a_src_next;
  logic             a_reg, b_reg, a_reg_next, b_reg_next, shl, shr;

  // EX/MEM beats MEM/WB; register 0 is hardwired and never forwarded
  function automatic logic [WIDTH-1:0] fwd(input logic [4:0] addr, input logic [WIDTH-1:0] val);
    fwd = (exmem_reg_write && exmem_rd == addr && addr != 5'd0) ? exmem_result :
          (memwb_reg_write && memwb_rd == addr && addr != 5'd0) ? memwb_result : val;
  endfunction

  assign id_ready = ~ex_stall;

  // Operand selection for a captured instruction, plus which held operand is a register and which one
  always_comb begin
    rs_fwd     = fwd(id_rs_addr, id_rs_val);
    rt_fwd     = fwd(id_rt_addr, id_rt_val);
    imm_ext    = {{(WIDTH-16){id_imm_sext & id_imm[15]}}, id_imm};
    shamt_ext  = {{(WIDTH-5){1'b0}}, id_shamt};
    shl        = id_use_shamt && id_alu_sel == 4'h0;
    shr        = id_use_shamt && id_alu_sel == 4'h1;
    a_next     = shl ? rt_fwd : shr ? shamt_ext : rs_fwd;
    b_next     = shl ? shamt_ext : shr ? rt_fwd : id_use_imm ? imm_ext : rt_fwd;
    a_src_next = shl ? id_rt_addr : id_rs_addr;
    a_reg_next = ~shr;
    b_reg_next = shr | (~shl & ~id_use_imm);
    a_hold     = a_reg ? fwd(a_src, A) : A;
    b_hold     = b_reg ? fwd(b_src, B) : B;
  end

  // Pipeline register: reset > flush > stall (refresh held operands) > capture > bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      A            <= '0;
      B            <= '0;
      ALU_Sel      <= '0;
      ex_valid     <= 1'b0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      bubble_cnt   <= '0;
      a_src        <= '0;
      b_src        <= '0;
      a_reg        <= 1'b0;
      b_reg        <= 1'b0;
    end else if (ex_flush || (!ex_stall && !id_valid)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      bubble_cnt   <= &bubble_cnt ? bubble_cnt : bubble_cnt + 1'b1;
    end else if (ex_stall) begin
      A <= a_hold;
      B <= b_hold;
    end else begin
      A            <= a_next;
      B            <= b_next;
      ALU_Sel      <= id_alu_sel;
      ex_valid     <= 1'b1;
      ex_rd_addr   <= id_rd_addr;
      ex_reg_write <= id_reg_write;
      a_src        <= a_src_next;
      b_src        <= id_rt_addr;
      a_reg        <= a_reg_next;
      b_reg        <= b_reg_next;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, id_valid, id_ready, id_imm_sext, id_use_shamt, id_use_imm, id_reg_write;
  logic [4:0] id_rs_addr, id_rt_addr, id_rd_addr, id_shamt, exmem_rd, memwb_rd, ex_rd_addr;
  logic [31:0] id_rs_val, id_rt_val, exmem_result, memwb_result, A, B;
  logic [15:0] id_imm;
  logic [3:0] id_alu_sel, ALU_Sel;
  logic exmem_reg_write, memwb_reg_write, ex_stall, ex_flush, ex_valid, ex_reg_write;
  logic [CW-1:0] bubble_cnt;

  int checks = 0, passed = 0, failed = 0;

  logic [31:0] m_a, m_b;
  logic [3:0] m_sel;
  logic m_valid, m_wr;
  logic [4:0] m_rd;
  int m_cnt, m_asrc, m_bsrc, prev_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm), .id_imm_sext(id_imm_sext),
    .id_shamt(id_shamt), .id_use_shamt(id_use_shamt), .id_use_imm(id_use_imm),
    .id_alu_sel(id_alu_sel), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mfwd(input int r, input logic [31:0] v);
    if (r > 0 && exmem_reg_write && int'(exmem_rd) == r) return exmem_result;
    if (r > 0 && memwb_reg_write && int'(memwb_rd) == r) return memwb_result;
    return v;
  endfunction

  task automatic model_step();
    logic [31:0] rs, rt, imm, sh;
    if (!rst) begin
      m_a = 0; m_b = 0; m_sel = 0; m_valid = 0; m_rd = 0; m_wr = 0; m_cnt = 0;
      m_asrc = -1; m_bsrc = -1;
    end else if (ex_flush || (!ex_stall && !id_valid)) begin
      m_valid = 0; m_wr = 0;
      m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
    end else if (ex_stall) begin
      if (m_asrc >= 0) m_a = mfwd(m_asrc, m_a);
      if (m_bsrc >= 0) m_b = mfwd(m_bsrc, m_b);
    end else begin
      rs = mfwd(int'(id_rs_addr), id_rs_val);
      rt = mfwd(int'(id_rt_addr), id_rt_val);
      imm = id_imm_sext ? 32'($signed(id_imm)) : 32'(id_imm);
      sh = 32'(id_shamt);
      if (id_use_shamt && id_alu_sel == 0) begin
        m_a = rt; m_b = sh; m_asrc = int'(id_rt_addr); m_bsrc = -1;
      end else if (id_use_shamt && id_alu_sel == 1) begin
        m_a = sh; m_b = rt; m_asrc = -1; m_bsrc = int'(id_rt_addr);
      end else begin
        m_a = rs; m_asrc = int'(id_rs_addr);
        m_b = id_use_imm ? imm : rt; m_bsrc = id_use_imm ? -1 : int'(id_rt_addr);
      end
      m_sel = id_alu_sel; m_valid = 1; m_rd = id_rd_addr; m_wr = id_reg_write;
    end
  endtask

  task automatic check_all();
    chk("A", A, m_a);
    chk("B", B, m_b);
    chk("ALU_Sel", 32'(ALU_Sel), 32'(m_sel));
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_rd_addr", 32'(ex_rd_addr), 32'(m_rd));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(m_wr));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
  endtask

  task automatic step();
    #1;
    chk("id_ready", 32'(id_ready), 32'(!ex_stall));
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 1; id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_imm_sext = 0; id_shamt = 0;
    id_use_shamt = 0; id_use_imm = 0; id_alu_sel = 0; id_reg_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0; ex_stall = 0; ex_flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [31:0] rsv, input logic [4:0] rt,
                       input logic [31:0] rtv, input logic [3:0] sel);
    id_valid = 1; id_rs_addr = rs; id_rs_val = rsv; id_rt_addr = rt; id_rt_val = rtv;
    id_alu_sel = sel; id_rd_addr = 5'd9; id_reg_write = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    step();
    chk("reset_A", A, 32'h0);
    chk("reset_valid", 32'(ex_valid), 32'h0);
    idle();
    issue(5'd3, 32'h10, 5'd4, 32'h20, 4'h6);
    step();
    chk("cap_A", A, 32'h10);
    chk("cap_B", B, 32'h20);
    chk("cap_sel", 32'(ALU_Sel), 32'h6);
    chk("cap_valid", 32'(ex_valid), 32'h1);
    idle();
    issue(5'd5, 32'h1, 5'd2, 32'h2, 4'h3);
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hBBBB;
    step();
    chk("fwd_prio", A, 32'hAAAA);
    idle();
    issue(5'd0, 32'h1234, 5'd2, 32'h2, 4'h3);
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h1;
    step();
    chk("fwd_r0", A, 32'h1234);
    idle();
    issue(5'd1, 32'h1, 5'd2, 32'h2, 4'h2);
    id_use_imm = 1; id_imm = 16'h8000; id_imm_sext = 1;
    step();
    chk("imm_sext", B, 32'hFFFF8000);
    id_imm_sext = 0;
    step();
    chk("imm_zext", B, 32'h00008000);
    idle();
    issue(5'd1, 32'h1, 5'd6, 32'h80, 4'h1);
    id_use_shamt = 1; id_shamt = 5'd4;
    step();
    chk("shr_A", A, 32'h4);
    chk("shr_B", B, 32'h80);
    idle();
    issue(5'd1, 32'h1, 5'd7, 32'h11, 4'h2);
    step();
    issue(5'd3, 32'h3, 5'd4, 32'h4, 4'h5);
    ex_stall = 1; memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'h55;
    #1;
    chk("stall_ready", 32'(id_ready), 32'h0);
    step();
    chk("stall_B", B, 32'h55);
    chk("stall_sel", 32'(ALU_Sel), 32'h2);
    idle();
    ex_stall = 1; ex_flush = 1; id_valid = 1;
    prev_cnt = m_cnt;
    step();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_wr", 32'(ex_reg_write), 32'h0);
    chk("flush_cnt", 32'(bubble_cnt), 32'(prev_cnt + 1));
    idle();
    step();
    step();
    issue(5'd1, 32'h7, 5'd2, 32'h8, 4'h4);
    step();
    chk("pre_rst_valid", 32'(ex_valid), 32'h1);
    chk("pre_rst_cnt", 32'(bubble_cnt), 32'h3);
    rst = 0;
    step();
    chk("mid_rst_A", A, 32'h0);
    chk("mid_rst_cnt", 32'(bubble_cnt), 32'h0);
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("sat_cnt", 32'(bubble_cnt), 32'h3);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) != 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs_addr = 5'($urandom_range(0, 7));
      id_rt_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom);
      id_rs_val = $urandom; id_rt_val = $urandom;
      id_imm = 16'($urandom); id_imm_sext = 1'($urandom);
      id_shamt = 5'($urandom); id_use_shamt = 1'($urandom); id_use_imm = 1'($urandom);
      id_alu_sel = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom);
      id_reg_write = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
      ex_stall = ($urandom_range(0, 3) == 0);
      ex_flush = ($urandom_range(0, 7) == 0);
      step();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
